// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller.
// Rising edges on peripheral IRQ lines are latched into PEND and masked by ENA.
// The lowest-numbered pending and enabled source is requested to the core.
// Once the core takes the request, a one-cycle ack/ID pair is broadcast so the
// peripheral can drop its line. The controller then stays in service until
// software writes a matching End-Of-Interrupt.
//
// Bus handshake: a write is a single-cycle strobe (write_i) qualified per byte
// by data_be_i. There is no ready/stall; every write is accepted in the cycle it
// is presented. Reads are combinational from addr_i.
// Core handshake: cpu_irq_o acts as valid and cpu_irq_take_i acts as ready.
// The request is consumed on the clock edge where both are high. The request
// may be withdrawn without a take if its source is disabled or unpended.
module irq_ctrl #(
    parameter int NUM_IRQ = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               write_i,
    input  logic [3:0]         data_be_i,
    input  logic [4:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic               cpu_irq_o,
    output logic [4:0]         cpu_irq_id_o,
    input  logic               cpu_irq_take_i,
    output logic               irq_ack_o,
    output logic [4:0]         irq_id_o
);

    // Only the low NUM_IRQ bits of any register exist.
    localparam logic [31:0] VALID_MASK =
        (NUM_IRQ >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_IRQ) - 32'd1);

    localparam logic [2:0] A_PEND   = 3'd0;
    localparam logic [2:0] A_ENA    = 3'd1;
    localparam logic [2:0] A_SWI    = 3'd2;
    localparam logic [2:0] A_INSERV = 3'd3;
    localparam logic [2:0] A_EOI    = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        SERV = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cur_id;
    logic [31:0] pend_q;
    logic [31:0] ena_q;
    logic [31:0] src_q;
    logic [31:0] src_ext;
    logic [31:0] be_mask;
    logic [31:0] swi_set;
    logic [31:0] pend_d;
    logic        ena_wr;
    logic        swi_wr;
    logic        eoi_wr;
    logic        cand_valid;
    logic [4:0]  cand_id;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];

    // Widen the source vector to the 32-bit register layout.
    always_comb begin
        src_ext = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            src_ext[i] = irq_src_i[i];
        end
    end

    // Bus write decode and byte-enable expansion.
    always_comb begin
        be_mask = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                   {8{data_be_i[1]}}, {8{data_be_i[0]}}};
        ena_wr  = write_i && (addr_i[4:2] == A_ENA);
        swi_wr  = write_i && (addr_i[4:2] == A_SWI);
        eoi_wr  = write_i && (addr_i[4:2] == A_EOI) && data_be_i[0];
        swi_set = swi_wr ? (wdata_i & be_mask) : 32'd0;
    end

    // Next PEND: ack clears the in-flight ID, new edges and SWI sets win over it.
    always_comb begin
        pend_d = pend_q;
        if (state == ACK) begin
            pend_d[cur_id] = 1'b0;
        end
        pend_d = (pend_d | (src_ext & ~src_q) | swi_set) & VALID_MASK;
    end

    // Fixed priority: lowest index among pending and enabled sources.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i] && ena_q[i]) begin
                cand_valid = 1'b1;
                cand_id    = 5'(i);
            end
        end
    end

    // Edge-detect history, pending bits and enable mask.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            src_q  <= '0;
            pend_q <= '0;
            ena_q  <= '0;
        end else begin
            src_q  <= src_ext;
            pend_q <= pend_d;
            if (ena_wr) begin
                ena_q <= ((ena_q & ~be_mask) | (wdata_i & be_mask)) & VALID_MASK;
            end
        end
    end

    // Request/ack/service sequencer with registered core and peripheral outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cur_id       <= '0;
            cpu_irq_o    <= 1'b0;
            cpu_irq_id_o <= '0;
            irq_ack_o    <= 1'b0;
            irq_id_o     <= '0;
        end else begin
            irq_ack_o <= 1'b0;
            irq_id_o  <= '0;
            unique case (state)
                IDLE: begin
                    if (cand_valid) begin
                        cur_id       <= cand_id;
                        cpu_irq_o    <= 1'b1;
                        cpu_irq_id_o <= cand_id;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (cpu_irq_take_i) begin
                        cpu_irq_o    <= 1'b0;
                        cpu_irq_id_o <= '0;
                        irq_ack_o    <= 1'b1;
                        irq_id_o     <= cur_id;
                        state        <= ACK;
                    end else if (!ena_q[cur_id] || !pend_q[cur_id]) begin
                        cpu_irq_o    <= 1'b0;
                        cpu_irq_id_o <= '0;
                        state        <= IDLE;
                    end
                end
                ACK: begin
                    state <= SERV;
                end
                SERV: begin
                    if (eoi_wr && (wdata_i[4:0] == cur_id)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Register read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        rdata_o = 32'd0;
        unique case (addr_i[4:2])
            A_PEND:   rdata_o = pend_q;
            A_ENA:    rdata_o = ena_q;
            A_INSERV: rdata_o = {22'd0, cpu_irq_o, (state == SERV), 3'd0, cur_id};
            default:  rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a per-cycle vector table for the main request,
// priority and EOI flows, followed by hand-written multi-cycle sequences.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [31:0] src = 32'd0;
    logic        cpu_irq;
    logic [4:0]  cpu_irq_id;
    logic        take = 1'b0;
    logic        ack;
    logic [4:0]  ack_id;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [4:0] R_PEND = 5'h00, R_ENA = 5'h04, R_SWI = 5'h08,
                           R_INS = 5'h0C, R_EOI = 5'h10;

    irq_ctrl #(.NUM_IRQ(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .write_i       (write),
        .data_be_i     (be),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rdata_o       (rdata),
        .irq_src_i     (src),
        .cpu_irq_o     (cpu_irq),
        .cpu_irq_id_o  (cpu_irq_id),
        .cpu_irq_take_i(take),
        .irq_ack_o     (ack),
        .irq_id_o      (ack_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] src;
        logic        take;
        logic        exp_irq;
        logic [4:0]  exp_irq_id;
        logic        exp_ack;
        logic [4:0]  exp_ack_id;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(input logic wr, input logic [3:0] b, input logic [4:0] a,
                                input logic [31:0] wd, input logic [31:0] s, input logic tk,
                                input logic ei, input logic [4:0] eid, input logic ea,
                                input logic [4:0] eaid, input logic [31:0] er);
        vec_t v;
        v.wr = wr; v.be = b; v.addr = a; v.wdata = wd; v.src = s; v.take = tk;
        v.exp_irq = ei; v.exp_irq_id = eid; v.exp_ack = ea; v.exp_ack_id = eaid;
        v.exp_rdata = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then let it settle.
    task automatic apply(input logic wr, input logic [3:0] b, input logic [4:0] a,
                         input logic [31:0] wd, input logic [31:0] s, input logic tk);
        @(posedge clk);
        #1;
        write = wr; be = b; addr = a; wdata = wd; src = s; take = tk;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ei, input logic [4:0] eid,
                              input logic ea, input logic [4:0] eaid, input logic [31:0] er);
        check({tag, " cpu_irq"}, 32'(cpu_irq), 32'(ei));
        check({tag, " cpu_irq_id"}, 32'(cpu_irq_id), 32'(eid));
        check({tag, " irq_ack"}, 32'(ack), 32'(ea));
        check({tag, " irq_id"}, 32'(ack_id), 32'(eaid));
        check({tag, " rdata"}, rdata, er);
    endtask

    initial begin
        // ID 7 flow: enable, edge, request, take, ack, mismatched and matching EOI.
        vecs[0]  = mk(1, 4'hF, R_ENA, 32'h80, 32'h00, 0, 0, 0, 0, 0, 32'h000);
        vecs[1]  = mk(0, 4'h0, R_ENA, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h080);
        vecs[2]  = mk(0, 4'h0, R_PEND, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h000);
        vecs[3]  = mk(0, 4'h0, R_PEND, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h080);
        vecs[4]  = mk(0, 4'h0, R_INS, 32'h00, 32'h80, 1, 1, 7, 0, 0, 32'h207);
        vecs[5]  = mk(0, 4'h0, R_PEND, 32'h00, 32'h80, 0, 0, 0, 1, 7, 32'h080);
        vecs[6]  = mk(0, 4'h0, R_INS, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h107);
        vecs[7]  = mk(0, 4'h0, R_PEND, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h000);
        vecs[8]  = mk(1, 4'h1, R_EOI, 32'h05, 32'h00, 0, 0, 0, 0, 0, 32'h000);
        vecs[9]  = mk(0, 4'h0, R_INS, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h107);
        vecs[10] = mk(1, 4'h1, R_EOI, 32'h07, 32'h00, 0, 0, 0, 0, 0, 32'h000);
        vecs[11] = mk(0, 4'h0, R_INS, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h007);
        vecs[12] = mk(0, 4'h0, R_SWI, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h000);
        vecs[13] = mk(0, 4'h0, 5'h1C, 32'h00, 32'h00, 0, 0, 0, 0, 0, 32'h000);
        // Simultaneous edges on 3 and 7: 3 first, 7 follows two cycles after EOI(3).
        vecs[14] = mk(1, 4'hF, R_ENA, 32'h88, 32'h00, 0, 0, 0, 0, 0, 32'h080);
        vecs[15] = mk(0, 4'h0, R_PEND, 32'h00, 32'h88, 0, 0, 0, 0, 0, 32'h000);
        vecs[16] = mk(0, 4'h0, R_PEND, 32'h00, 32'h88, 0, 0, 0, 0, 0, 32'h088);
        vecs[17] = mk(0, 4'h0, R_INS, 32'h00, 32'h88, 1, 1, 3, 0, 0, 32'h203);
        vecs[18] = mk(0, 4'h0, R_PEND, 32'h00, 32'h88, 0, 0, 0, 1, 3, 32'h088);
        vecs[19] = mk(0, 4'h0, R_PEND, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h080);
        vecs[20] = mk(1, 4'h1, R_EOI, 32'h03, 32'h80, 0, 0, 0, 0, 0, 32'h000);
        vecs[21] = mk(0, 4'h0, R_INS, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h003);
        vecs[22] = mk(0, 4'h0, R_INS, 32'h00, 32'h80, 1, 1, 7, 0, 0, 32'h207);
        vecs[23] = mk(0, 4'h0, R_PEND, 32'h00, 32'h80, 0, 0, 0, 1, 7, 32'h080);
        vecs[24] = mk(0, 4'h0, R_PEND, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h000);
        // EOI without byte-enable 0 must be ignored.
        vecs[25] = mk(1, 4'hE, R_EOI, 32'h07, 32'h80, 0, 0, 0, 0, 0, 32'h000);
        vecs[26] = mk(0, 4'h0, R_INS, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h107);
        vecs[27] = mk(1, 4'h1, R_EOI, 32'h07, 32'h80, 0, 0, 0, 0, 0, 32'h000);
        vecs[28] = mk(0, 4'h0, R_INS, 32'h00, 32'h80, 0, 0, 0, 0, 0, 32'h007);

        // Reset block: hold reset for a few cycles and check the idle outputs.
        repeat (3) apply(0, 4'h0, R_PEND, 32'h0, 32'h0, 0);
        check_outs("reset", 0, 0, 0, 0, 32'h0);
        apply(0, 4'h0, R_ENA, 32'h0, 32'h0, 0);
        check("reset ENA", rdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            apply(vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].src, vecs[i].take);
            check_outs($sformatf("v%0d", i), vecs[i].exp_irq, vecs[i].exp_irq_id,
                       vecs[i].exp_ack, vecs[i].exp_ack_id, vecs[i].exp_rdata);
        end

        // Source 7 held high after its ack: no re-trigger for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            apply(0, 4'h0, R_PEND, 32'h0, 32'h80, 0);
            check($sformatf("hold%0d PEND", i), rdata, 32'h0);
            check($sformatf("hold%0d cpu_irq", i), 32'(cpu_irq), 32'h0);
        end
        // Drop and re-raise: it pends again and is requested.
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 0);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h80, 0);
        check("rearm PEND N", rdata, 32'h0);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h80, 0);
        check("rearm PEND N+1", rdata, 32'h80);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h80, 1);
        check_outs("rearm req", 1, 7, 0, 0, 32'h80);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 0);
        check_outs("rearm ack", 0, 0, 1, 7, 32'h80);
        apply(1, 4'h1, R_EOI, 32'h7, 32'h00, 0);
        apply(0, 4'h0, R_INS, 32'h0, 32'h00, 0);
        check("rearm INSERV", rdata, 32'h007);

        // Software interrupt while disabled, then enable, then withdraw by disabling.
        apply(1, 4'hF, R_ENA, 32'h0, 32'h00, 0);
        apply(1, 4'hF, R_SWI, 32'h4, 32'h00, 0);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 0);
        check_outs("swi pend", 0, 0, 0, 0, 32'h4);
        apply(0, 4'h0, R_SWI, 32'h0, 32'h00, 0);
        check_outs("swi read", 0, 0, 0, 0, 32'h0);
        apply(1, 4'hF, R_ENA, 32'h4, 32'h00, 0);
        check("swi ena cpu_irq", 32'(cpu_irq), 32'h0);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 0);
        check("swi idle cpu_irq", 32'(cpu_irq), 32'h0);
        apply(1, 4'hF, R_ENA, 32'h0, 32'h00, 0);
        check_outs("swi req", 1, 2, 0, 0, 32'h4);
        apply(0, 4'h0, R_INS, 32'h0, 32'h00, 0);
        check_outs("swi withdraw", 1, 2, 0, 0, 32'h202);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 0);
        check_outs("swi dropped", 0, 0, 0, 0, 32'h4);
        apply(0, 4'h0, R_INS, 32'h0, 32'h00, 0);
        check("swi idle INSERV", rdata, 32'h002);

        // Reset during the ACK cycle; source 0 held high across reset release.
        apply(1, 4'hF, R_ENA, 32'h4, 32'h00, 0);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 0);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h00, 1);
        check_outs("pre-rst req", 1, 2, 0, 0, 32'h4);
        apply(0, 4'h0, R_PEND, 32'h0, 32'h01, 0);
        check_outs("pre-rst ack", 0, 0, 1, 2, 32'h4);
        rst_n = 1'b0;
        apply(0, 4'h0, R_PEND, 32'h0, 32'h01, 0);
        check_outs("rst ack abort", 0, 0, 0, 0, 32'h0);
        apply(0, 4'h0, R_ENA, 32'h0, 32'h01, 0);
        check_outs("rst ENA", 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        apply(0, 4'h0, R_PEND, 32'h0, 32'h01, 0);
        check_outs("post-rst pend", 0, 0, 0, 0, 32'h1);
        apply(1, 4'h2, R_ENA, 32'h80, 32'h01, 0);
        apply(0, 4'h0, R_ENA, 32'h0, 32'h01, 0);
        check_outs("be masked ENA", 0, 0, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between peripheral IRQ lines and the core.
- Latches rising edges of up to 32 peripheral sources, masks them, and picks one by fixed priority.
- Raises a request to the core and waits for the core to take it.
- Then broadcasts the acknowledge/ID pair that peripherals (e.g. timer on ID 7) use to drop their IRQ outputs.
- Holds an in-service state until software writes End-Of-Interrupt.

Parameters:
- NUM_IRQ, 32, number of source lines; legal range 1..32; IDs are 0..NUM_IRQ-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- write_i  in  1  bus write strobe.
- data_be_i  in  4  byte enables for writes.
- addr_i  in  5  byte address; bits [1:0] ignored.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, combinational from addr_i.
- irq_src_i  in  NUM_IRQ  peripheral IRQ levels; each source holds high until acked.
- cpu_irq_o  out  1  interrupt request to core.
- cpu_irq_id_o  out  5  ID of the requested interrupt; valid while cpu_irq_o=1.
- cpu_irq_take_i  in  1  core accepts the request; sampled only while cpu_irq_o=1.
- irq_ack_o  out  1  one-cycle acknowledge broadcast to peripherals.
- irq_id_o  out  5  ID accompanying irq_ack_o; 0 when irq_ack_o=0.

Behaviour:
- Register map (word offsets):
  - 0x00 PEND: RO, pending bits.
  - 0x04 ENA: RW, enable mask.
  - 0x08 SWI: WO, write-1-sets PEND bits; reads 0.
  - 0x0C INSERV: RO; [4:0]=current ID, [8]=in-service valid, [9]=request active.
  - 0x10 EOI: WO; [4:0]=ID to retire; reads 0.
  - All other offsets read 0; writes to them are ignored.
- Byte enables:
  - Apply to ENA and SWI writes.
  - EOI write takes effect only if data_be_i[0]=1.
- Register bits at index >= NUM_IRQ read 0 and are not writable.
- Edge detect:
  - src_q <= irq_src_i every cycle.
  - PEND[i] sets when irq_src_i[i] & ~src_q[i], or on an SWI write of 1.
  - Set has priority over a same-cycle clear of the same bit.
- Candidate = lowest index i with PEND[i] & ENA[i].
- FSM states:
  - IDLE:
    - cpu_irq_o=0.
    - If a candidate exists: cur_id <= candidate, go to REQ.
  - REQ:
    - cpu_irq_o=1, cpu_irq_id_o=cur_id.
    - cur_id is frozen; no preemption by a higher-priority source.
    - If cpu_irq_take_i=1: go to ACK.
    - Else if ENA[cur_id] or PEND[cur_id] becomes 0 (e.g. via ENA write): go to IDLE (request withdrawn, cpu_irq_o falls next cycle).
  - ACK (exactly 1 cycle):
    - irq_ack_o=1, irq_id_o=cur_id, cpu_irq_o=0.
    - Clear PEND[cur_id] (unless re-set the same cycle).
    - Go to SERV.
  - SERV:
    - INSERV[8]=1; no new requests are raised (no nesting).
    - EOI write with wdata_i[4:0]==cur_id: go to IDLE.
    - Mismatched EOI: ignored, stay in SERV.
- Latency:
  - Source edge in cycle N: PEND set at edge N+1, cpu_irq_o high from N+2.
  - take in cycle M: irq_ack_o high in cycle M+1.
  - After a matching EOI in cycle K, a pending candidate raises cpu_irq_o by K+2.
- Source still high after ack: no re-trigger (edge only). It must fall and rise again to re-pend.
- EOI written while in IDLE/REQ/ACK: ignored.
- Reset (rst_ni=0 at a clock edge):
  - PEND=0, ENA=0, src_q=0, cur_id=0, FSM=IDLE.
  - cpu_irq_o=0, cpu_irq_id_o=0, irq_ack_o=0, irq_id_o=0.
  - Reset in any state, including mid-ACK, aborts with no ack pulse.
- Sources already high at reset release: src_q=0, so they pend on the first cycle after reset.

Test Plan:
- ENA=0x80; raise irq_src_i[7] at cycle N -> PEND=0x80 at N+1; cpu_irq_o=1, cpu_irq_id_o=7 at N+2. Pulse take -> irq_ack_o=1, irq_id_o=7 for one cycle; PEND=0; INSERV=0x107.
- Simultaneous edges on sources 3 and 7, ENA=0x88 -> ID 3 served first. After EOI(3), ID 7 requested within 2 cycles.
- In SERV for ID 7: write EOI=5 -> stays in SERV. Then write EOI=7 -> returns to IDLE, INSERV[8]=0.
- ENA=0; SWI write 0x4 -> PEND=0x4, no cpu_irq_o. Then ENA=0x4 -> request with ID 2. During REQ write ENA=0 -> cpu_irq_o drops, FSM IDLE, PEND stays 0x4.
- Source 7 held high through ack and for 20 cycles -> no second pend. Drop and re-raise -> PEND[7]=1 again.
- Assert rst_ni=0 during the ACK cycle -> next cycle all outputs 0, PEND=0, ENA=0. Write ENA=0x80 with data_be_i=4'b0010 -> ENA stays 0.
